fpu_comp_axis: RTL and testbench

Parametrised, fully pipelined floating-point compare unit with a selectable predicate. It joins three AXI-Stream inputs (operand A, operand B, operation code) into one transaction and returns an 8-bit result word on an AXI-Stream master with full backpressure. IEEE-754 semantics are honoured for NaN, infinity and signed zero. It replaces the fixed "A less than B" half-precision comparator in the FPU_16 datapath and also serves wider formats via parameters.

---
 rtl/fpu_comp_axis.sv | 178 +++++++++++++++++
 tb/tb_fpu_comp_axis.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_comp_axis.sv
// Two-stage pipelined floating-point compare with selectable predicate.
// Joins operand A, operand B and op code streams into one transaction and
// returns {unordered, predicate} on an AXI-Stream master with backpressure.
module fpu_comp_axis #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10,
    parameter int unsigned OUT_W = 8,
    localparam int unsigned DW = 1 + EXP_W + MAN_W
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [DW-1:0]    s_axis_a_tdata,
    input  logic             s_axis_a_tvalid,
    output logic             s_axis_a_tready,
    input  logic [DW-1:0]    s_axis_b_tdata,
    input  logic             s_axis_b_tvalid,
    output logic             s_axis_b_tready,
    input  logic [2:0]       s_axis_operation_tdata,
    input  logic             s_axis_operation_tvalid,
    output logic             s_axis_operation_tready,
    output logic [OUT_W-1:0] m_axis_result_tdata,
    output logic             m_axis_result_tvalid,
    input  logic             m_axis_result_tready
);

    localparam logic [2:0] OpEq = 3'd0;
    localparam logic [2:0] OpLt = 3'd1;
    localparam logic [2:0] OpLe = 3'd2;
    localparam logic [2:0] OpGt = 3'd3;
    localparam logic [2:0] OpGe = 3'd4;
    localparam logic [2:0] OpNe = 3'd5;
    localparam logic [2:0] OpUn = 3'd6;

    // Stage 1: operand classification
    logic       v1_q, v1_d;
    logic       nan_a_q, nan_a_d;
    logic       nan_b_q, nan_b_d;
    logic       zero_ab_q, zero_ab_d;
    logic       sign_a_q, sign_a_d;
    logic       sign_b_q, sign_b_d;
    logic       mag_gt_q, mag_gt_d;
    logic       mag_eq_q, mag_eq_d;
    logic [2:0] op_q, op_d;

    // Stage 2: result word
    logic             v2_q, v2_d;
    logic [OUT_W-1:0] res_q, res_d;

    logic adv1, adv2, accept;

    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] man_a, man_b;
    logic [DW-2:0]    mag_a, mag_b;

    logic             unord, eq, gt, lt, pred;
    logic [OUT_W-1:0] res_word;

    // Handshake: all three inputs are consumed together or not at all
    always_comb begin
        adv2   = ~v2_q | m_axis_result_tready;
        adv1   = ~v1_q | adv2;
        // Gating with aresetn keeps tready low while reset is held
        accept = aresetn & s_axis_a_tvalid & s_axis_b_tvalid & s_axis_operation_tvalid & adv1;
        s_axis_a_tready         = accept;
        s_axis_b_tready         = accept;
        s_axis_operation_tready = accept;
    end

    // Field extraction; magnitude is everything below the sign bit
    always_comb begin
        exp_a = s_axis_a_tdata[DW-2:MAN_W];
        exp_b = s_axis_b_tdata[DW-2:MAN_W];
        man_a = s_axis_a_tdata[MAN_W-1:0];
        man_b = s_axis_b_tdata[MAN_W-1:0];
        mag_a = s_axis_a_tdata[DW-2:0];
        mag_b = s_axis_b_tdata[DW-2:0];
    end

    // Stage 1 next state: load classification only on an accepted transaction
    always_comb begin
        v1_d      = v1_q;
        nan_a_d   = nan_a_q;
        nan_b_d   = nan_b_q;
        zero_ab_d = zero_ab_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        mag_gt_d  = mag_gt_q;
        mag_eq_d  = mag_eq_q;
        op_d      = op_q;
        if (adv1) begin
            v1_d = accept;
            if (accept) begin
                nan_a_d   = (&exp_a) & (|man_a);
                nan_b_d   = (&exp_b) & (|man_b);
                zero_ab_d = ~(|mag_a) & ~(|mag_b);
                sign_a_d  = s_axis_a_tdata[DW-1];
                sign_b_d  = s_axis_b_tdata[DW-1];
                mag_gt_d  = mag_a > mag_b;
                mag_eq_d  = mag_a == mag_b;
                op_d      = s_axis_operation_tdata;
            end
        end
    end

    // Ordered relation and predicate select from the stage 1 classification
    always_comb begin
        unord = nan_a_q | nan_b_q;
        // +0 and -0 are equal despite differing sign bits
        eq    = zero_ab_q | ((sign_a_q == sign_b_q) & mag_eq_q);
        if (zero_ab_q) begin
            gt = 1'b0;
        end else if (sign_a_q != sign_b_q) begin
            gt = ~sign_a_q;
        end else if (sign_a_q) begin
            // Both negative: larger magnitude is the smaller value
            gt = ~mag_gt_q & ~mag_eq_q;
        end else begin
            gt = mag_gt_q;
        end
        lt = ~eq & ~gt;
        case (op_q)
            OpEq:    pred = ~unord & eq;
            OpLt:    pred = ~unord & lt;
            OpLe:    pred = ~unord & (lt | eq);
            OpGt:    pred = ~unord & gt;
            OpGe:    pred = ~unord & (gt | eq);
            OpNe:    pred = unord | ~eq;
            OpUn:    pred = unord;
            default: pred = 1'b0;
        endcase
        res_word    = '0;
        res_word[0] = pred;
        res_word[1] = unord;
    end

    // Stage 2 next state: hold while stalled, otherwise take stage 1
    always_comb begin
        v2_d  = v2_q;
        res_d = res_q;
        if (adv2) begin
            v2_d  = v1_q;
            res_d = v1_q ? res_word : '0;
        end
    end

    // Pipeline state registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v1_q      <= 1'b0;
            nan_a_q   <= 1'b0;
            nan_b_q   <= 1'b0;
            zero_ab_q <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            mag_gt_q  <= 1'b0;
            mag_eq_q  <= 1'b0;
            op_q      <= 3'd0;
            v2_q      <= 1'b0;
            res_q     <= '0;
        end else begin
            v1_q      <= v1_d;
            nan_a_q   <= nan_a_d;
            nan_b_q   <= nan_b_d;
            zero_ab_q <= zero_ab_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            mag_gt_q  <= mag_gt_d;
            mag_eq_q  <= mag_eq_d;
            op_q      <= op_d;
            v2_q      <= v2_d;
            res_q     <= res_d;
        end
    end

    assign m_axis_result_tvalid = v2_q;
    assign m_axis_result_tdata  = res_q;

endmodule

// File: tb/tb_fpu_comp_axis.sv
// Directed bench for fpu_comp_axis: predicates, special values, backpressure,
// join rule and asynchronous reset. Inputs are driven and outputs sampled
// on the falling edge.
module tb_fpu_comp_axis;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [15:0] a_data, b_data;
    logic        a_valid, b_valid, op_valid;
    logic [2:0]  op_data;
    logic        a_ready, b_ready, op_ready;
    logic [7:0]  r_data;
    logic        r_valid, r_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 aclk = ~aclk;

    fpu_comp_axis dut (
        .aclk                    (aclk),
        .aresetn                 (aresetn),
        .s_axis_a_tdata          (a_data),
        .s_axis_a_tvalid         (a_valid),
        .s_axis_a_tready         (a_ready),
        .s_axis_b_tdata          (b_data),
        .s_axis_b_tvalid         (b_valid),
        .s_axis_b_tready         (b_ready),
        .s_axis_operation_tdata  (op_data),
        .s_axis_operation_tvalid (op_valid),
        .s_axis_operation_tready (op_ready),
        .m_axis_result_tdata     (r_data),
        .m_axis_result_tvalid    (r_valid),
        .m_axis_result_tready    (r_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                         input logic v);
        a_data   = a;
        b_data   = b;
        op_data  = op;
        a_valid  = v;
        b_valid  = v;
        op_valid = v;
    endtask

    // One transaction with tready=1: accept, one empty cycle, result on the next
    task automatic send_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input logic [2:0] op, input logic [7:0] exp);
        @(negedge aclk);
        drive(a, b, op, 1'b1);
        #1;
        check({tag, "_tready"}, {29'd0, a_ready, b_ready, op_ready}, 32'h7);
        @(negedge aclk);
        drive(16'hdead, 16'hbeef, 3'd7, 1'b0);
        #1;
        check({tag, "_lat1"}, {31'd0, r_valid}, 32'd0);
        @(negedge aclk);
        #1;
        check({tag, "_valid"}, {31'd0, r_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, r_data}, {24'd0, exp});
    endtask

    logic [15:0] tx_a [4];
    logic [15:0] tx_b [4];
    logic [2:0]  tx_op [4];
    logic [7:0]  tx_exp [4];
    int sent, got;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset with all inputs valid: tready must stay low
        aresetn = 1'b0;
        r_ready = 1'b1;
        drive(16'h3c00, 16'h4000, 3'd1, 1'b1);
        repeat (2) @(negedge aclk);
        #1;
        check("rst_tvalid", {31'd0, r_valid}, 32'd0);
        check("rst_tdata", {24'd0, r_data}, 32'd0);
        check("rst_tready", {29'd0, a_ready, b_ready, op_ready}, 32'd0);
        drive(16'h0, 16'h0, 3'd0, 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;

        // Predicates and special values
        send_check("lt_1_2",   16'h3c00, 16'h4000, 3'd1, 8'h01);
        send_check("gt_1_2",   16'h3c00, 16'h4000, 3'd3, 8'h00);
        send_check("eq_pz_nz", 16'h0000, 16'h8000, 3'd0, 8'h01);
        send_check("lt_pz_nz", 16'h0000, 16'h8000, 3'd1, 8'h00);
        send_check("nan_eq",   16'h7e00, 16'h3c00, 3'd0, 8'h02);
        send_check("nan_ne",   16'h7e00, 16'h3c00, 3'd5, 8'h03);
        send_check("nan_un",   16'h7e00, 16'h3c00, 3'd6, 8'h03);
        send_check("nan_rsv",  16'h7e00, 16'h3c00, 3'd7, 8'h02);
        send_check("neg_gt",   16'hbc00, 16'hc000, 3'd3, 8'h01);
        send_check("ninf_lt",  16'hfc00, 16'hfbff, 3'd1, 8'h01);
        send_check("le_equal", 16'h3c00, 16'h3c00, 3'd2, 8'h01);
        send_check("ge_equal", 16'h3c00, 16'h3c00, 3'd4, 8'h01);
        send_check("sub_gt_z", 16'h0001, 16'h0000, 3'd3, 8'h01);
        send_check("inf_gt",   16'h7c00, 16'h7bff, 3'd3, 8'h01);
        send_check("ne_zeros", 16'h8000, 16'h0000, 3'd5, 8'h00);
        send_check("bnan_lt",  16'h3c00, 16'h7e01, 3'd1, 8'h02);
        send_check("rsv_ord",  16'h4000, 16'h3c00, 3'd7, 8'h00);
        send_check("mix_lt",   16'hbc00, 16'h3c00, 3'd1, 8'h01);
        send_check("mix_ge",   16'hbc00, 16'h3c00, 3'd4, 8'h00);
        send_check("inf_un",   16'h7c00, 16'hfc00, 3'd6, 8'h00);

        // Backpressure: 4 back-to-back, output stalled for the first 5 cycles
        tx_a[0] = 16'h3c00; tx_b[0] = 16'h4000; tx_op[0] = 3'd1; tx_exp[0] = 8'h01;
        tx_a[1] = 16'h7e00; tx_b[1] = 16'h3c00; tx_op[1] = 3'd0; tx_exp[1] = 8'h02;
        tx_a[2] = 16'h7e00; tx_b[2] = 16'h3c00; tx_op[2] = 3'd5; tx_exp[2] = 8'h03;
        tx_a[3] = 16'h3c00; tx_b[3] = 16'h4000; tx_op[3] = 3'd3; tx_exp[3] = 8'h00;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge aclk);
            r_ready = (cyc >= 5);
            if (sent < 4) drive(tx_a[sent], tx_b[sent], tx_op[sent], 1'b1);
            else          drive(16'h0, 16'h0, 3'd0, 1'b0);
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                check("bp_tready_low", {29'd0, a_ready, b_ready, op_ready}, 32'd0);
                check("bp_hold_valid", {31'd0, r_valid}, 32'd1);
                check("bp_hold_data", {24'd0, r_data}, {24'd0, tx_exp[0]});
            end
            if (cyc == 4) check("bp_buffered", sent, 2);
            if (r_valid && r_ready) begin
                check("bp_order", {24'd0, r_data}, {24'd0, tx_exp[got]});
                got++;
            end
            if (a_ready && sent < 4) sent++;
        end
        check("bp_count", got, 4);
        drive(16'h0, 16'h0, 3'd0, 1'b0);
        @(negedge aclk);
        #1;
        check("bp_no_dup", {31'd0, r_valid}, 32'd0);

        // Join rule: op stream absent, nothing may be consumed
        @(negedge aclk);
        drive(16'h3c00, 16'h4000, 3'd1, 1'b1);
        op_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("join_tready", {29'd0, a_ready, b_ready, op_ready}, 32'd0);
            check("join_tvalid", {31'd0, r_valid}, 32'd0);
            @(negedge aclk);
        end
        drive(16'h0, 16'h0, 3'd0, 1'b0);

        // Reset with two transactions in flight
        @(negedge aclk);
        drive(16'h3c00, 16'h4000, 3'd1, 1'b1);
        @(negedge aclk);
        drive(16'h7e00, 16'h3c00, 3'd5, 1'b1);
        @(negedge aclk);
        #1;
        check("inflight_valid", {31'd0, r_valid}, 32'd1);
        aresetn = 1'b0;
        #1;
        check("arst_tvalid", {31'd0, r_valid}, 32'd0);
        check("arst_tdata", {24'd0, r_data}, 32'd0);
        check("arst_tready", {29'd0, a_ready, b_ready, op_ready}, 32'd0);
        @(negedge aclk);
        drive(16'h0, 16'h0, 3'd0, 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            #1;
            check("post_rst_quiet", {31'd0, r_valid}, 32'd0);
        end

        // Normal operation after reset
        send_check("post_rst_lt", 16'h3c00, 16'h4000, 3'd1, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
